rocketcpu_wb_decoder: RTL and testbench



---
 rtl/rocketcpu_wb_decoder.sv | 168 ++++++++++++++++
 tb/tb_rocketcpu_wb_decoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rocketcpu_wb_decoder.sv
// Wishbone address decoder and bus watchdog for the merged CPU master port.
// Routes each access to mem/gpio/audio by adr[31:28] and turns unmapped or unanswered accesses into error acks.
module rocketcpu_wb_decoder #(
  parameter int          TIMEOUT = 255,
  parameter logic [31:0] ERR_RDT = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_s_adr,
  output logic [31:0] o_wb_s_dat,
  output logic [3:0]  o_wb_s_sel,
  output logic        o_wb_s_we,
  output logic        o_wb_mem_cyc,
  output logic        o_wb_gpio_cyc,
  output logic        o_wb_audio_cyc,
  input  logic [31:0] i_wb_mem_rdt,
  input  logic [31:0] i_wb_gpio_rdt,
  input  logic [31:0] i_wb_audio_rdt,
  input  logic        i_wb_mem_ack,
  input  logic        i_wb_gpio_ack,
  input  logic        i_wb_audio_ack,
  output logic        o_bus_err,
  output logic [31:0] o_err_adr,
  input  logic        i_err_clr
);

  localparam int             CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  localparam logic [1:0] SEL_MEM   = 2'd0;
  localparam logic [1:0] SEL_GPIO  = 2'd1;
  localparam logic [1:0] SEL_AUDIO = 2'd2;
  localparam logic [1:0] SEL_NONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RECOVER = 2'd2
  } state_e;

  state_e           state_q,   state_d;
  logic [1:0]       sel_q,     sel_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             bus_err_q, bus_err_d;
  logic [31:0]      err_adr_q, err_adr_d;

  logic        busy;
  logic        slv_ack;
  logic [31:0] slv_rdt;
  logic        term_ack;
  logic        term_unm;
  logic        term_to;
  logic        record_err;

  function automatic logic [1:0] decode(input logic [3:0] region);
    case (region)
      4'h0:    decode = SEL_MEM;
      4'h1:    decode = SEL_GPIO;
      4'h2:    decode = SEL_AUDIO;
      default: decode = SEL_NONE;
    endcase
  endfunction

  // State register: every flop here is control or error status, all cleared on reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      sel_q     <= SEL_NONE;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
      err_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
      err_adr_q <= err_adr_d;
    end
  end

  // Only the latched slave's ack is ever looked at, so stray acks cannot terminate a cycle
  always_comb begin
    slv_ack = 1'b0;
    slv_rdt = '0;
    case (sel_q)
      SEL_MEM:   begin slv_ack = i_wb_mem_ack;   slv_rdt = i_wb_mem_rdt;   end
      SEL_GPIO:  begin slv_ack = i_wb_gpio_ack;  slv_rdt = i_wb_gpio_rdt;  end
      SEL_AUDIO: begin slv_ack = i_wb_audio_ack; slv_rdt = i_wb_audio_rdt; end
      default:   begin slv_ack = 1'b0;           slv_rdt = '0;             end
    endcase
  end

  // Termination priority: real ack, then unmapped, then watchdog expiry
  always_comb begin
    busy       = (state_q == S_BUSY) && i_wb_cyc;
    term_ack   = busy && slv_ack;
    term_unm   = busy && !slv_ack && (sel_q == SEL_NONE);
    term_to    = busy && !slv_ack && (sel_q != SEL_NONE) && (cnt_q == TO_CNT);
    record_err = term_unm || term_to;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_wb_cyc) begin
          sel_d   = decode(i_wb_adr[31:28]);
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!i_wb_cyc) begin
          state_d = S_IDLE;
        end else if (term_ack || term_unm || term_to) begin
          state_d = S_RECOVER;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_err_d = bus_err_q;
    err_adr_d = err_adr_q;
    if (record_err) begin
      bus_err_d = 1'b1;
      err_adr_d = i_wb_adr;
    end else if (i_err_clr) begin
      bus_err_d = 1'b0;
    end
  end

  // Output logic
  always_comb begin
    o_wb_mem_cyc   = busy && (sel_q == SEL_MEM);
    o_wb_gpio_cyc  = busy && (sel_q == SEL_GPIO);
    o_wb_audio_cyc = busy && (sel_q == SEL_AUDIO);
    o_wb_ack       = term_ack || term_unm || term_to;
    if (term_ack) begin
      o_wb_rdt = slv_rdt;
    end else if (term_to) begin
      o_wb_rdt = ERR_RDT;
    end else begin
      o_wb_rdt = '0;
    end
    o_wb_s_adr = i_wb_adr;
    o_wb_s_dat = i_wb_dat;
    o_wb_s_sel = i_wb_sel;
    o_wb_s_we  = i_wb_we;
    o_bus_err  = bus_err_q;
    o_err_adr  = err_adr_q;
  end

endmodule

// File: tb/tb_rocketcpu_wb_decoder.sv
// Directed bench for rocketcpu_wb_decoder: a transaction-level timeline model predicts every output
// each cycle, and literal latency/data checks pin that model.
module tb_rocketcpu_wb_decoder;

  localparam int          TO   = 4;
  localparam logic [31:0] ERRV = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_wb_adr = '0, i_wb_dat = '0;
  logic [3:0]  i_wb_sel = '0;
  logic        i_wb_we = 1'b0, i_wb_cyc = 1'b0;
  logic [31:0] o_wb_rdt, o_wb_s_adr, o_wb_s_dat;
  logic        o_wb_ack, o_wb_s_we;
  logic [3:0]  o_wb_s_sel;
  logic        o_wb_mem_cyc, o_wb_gpio_cyc, o_wb_audio_cyc;
  logic [31:0] i_wb_mem_rdt = '0, i_wb_gpio_rdt = '0, i_wb_audio_rdt = '0;
  logic        i_wb_mem_ack = 1'b0, i_wb_gpio_ack = 1'b0, i_wb_audio_ack = 1'b0;
  logic        o_bus_err;
  logic [31:0] o_err_adr;
  logic        i_err_clr = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  bit model_go = 1'b0;

  // Transaction timeline model
  bit          m_active = 1'b0;
  int          m_t0 = 0, m_region = 3, m_delay = -1, m_ackc = 0;
  logic [31:0] m_rdt_exp = '0;
  bit          m_err_on_ack = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_eadr = '0;
  bit          stray_gpio = 1'b0;

  int          ack_off;
  logic [31:0] ack_rdt;

  always #5 clk = ~clk;

  rocketcpu_wb_decoder #(.TIMEOUT(TO), .ERR_RDT(ERRV)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc),
    .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
    .o_wb_s_adr(o_wb_s_adr), .o_wb_s_dat(o_wb_s_dat), .o_wb_s_sel(o_wb_s_sel), .o_wb_s_we(o_wb_s_we),
    .o_wb_mem_cyc(o_wb_mem_cyc), .o_wb_gpio_cyc(o_wb_gpio_cyc), .o_wb_audio_cyc(o_wb_audio_cyc),
    .i_wb_mem_rdt(i_wb_mem_rdt), .i_wb_gpio_rdt(i_wb_gpio_rdt), .i_wb_audio_rdt(i_wb_audio_rdt),
    .i_wb_mem_ack(i_wb_mem_ack), .i_wb_gpio_ack(i_wb_gpio_ack), .i_wb_audio_ack(i_wb_audio_ack),
    .o_bus_err(o_bus_err), .o_err_adr(o_err_adr), .i_err_clr(i_err_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Model update at the end of each cycle (cyc_n is the cycle that just ended)
  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_err    = 1'b0;
      m_eadr   = '0;
      model_go = 1'b1;
    end else begin
      if (m_active && i_wb_cyc && cyc_n == m_ackc && m_err_on_ack) begin
        m_err  = 1'b1;
        m_eadr = i_wb_adr;
      end else if (i_err_clr) begin
        m_err = 1'b0;
      end
      if (m_active && cyc_n >= m_t0 + 1 && (!i_wb_cyc || cyc_n == m_ackc))
        m_active = 1'b0;
    end
    cyc_n++;
  end

  // Slave responders: the selected slave acks delay cycles after its cyc first rises
  always @(posedge clk) begin
    #2;
    i_wb_mem_ack   = m_active && m_region == 0 && m_delay >= 0 && cyc_n == m_t0 + 1 + m_delay;
    i_wb_gpio_ack  = stray_gpio ||
                     (m_active && m_region == 1 && m_delay >= 0 && cyc_n == m_t0 + 1 + m_delay);
    i_wb_audio_ack = m_active && m_region == 2 && m_delay >= 0 && cyc_n == m_t0 + 1 + m_delay;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    bit in_busy;
    bit exp_ack;
    if (model_go) begin
      in_busy = m_active && i_wb_cyc && cyc_n >= m_t0 + 1 && cyc_n <= m_ackc;
      exp_ack = in_busy && cyc_n == m_ackc;
      chk("mem_cyc",   32'(o_wb_mem_cyc),   32'(in_busy && m_region == 0));
      chk("gpio_cyc",  32'(o_wb_gpio_cyc),  32'(in_busy && m_region == 1));
      chk("audio_cyc", 32'(o_wb_audio_cyc), 32'(in_busy && m_region == 2));
      chk("ack",       32'(o_wb_ack),       32'(exp_ack));
      chk("rdt",       o_wb_rdt,            exp_ack ? m_rdt_exp : 32'h0);
      chk("bus_err",   32'(o_bus_err),      32'(m_err));
      chk("err_adr",   o_err_adr,           m_eadr);
      chk("s_adr",     o_wb_s_adr,          i_wb_adr);
      chk("s_dat",     o_wb_s_dat,          i_wb_dat);
      chk("s_sel",     32'(o_wb_s_sel),     32'(i_wb_sel));
      chk("s_we",      32'(o_wb_s_we),      32'(i_wb_we));
    end
  end

  task automatic start_txn(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                           input logic we, input int delay, input logic [31:0] srdt);
    int region;
    @(posedge clk); #1;
    region = (adr[31:28] < 4'd3) ? int'(adr[31:28]) : 3;
    i_wb_adr = adr;
    i_wb_dat = dat;
    i_wb_sel = sel;
    i_wb_we  = we;
    i_wb_cyc = 1'b1;
    i_wb_mem_rdt   = (region == 0) ? srdt : 32'h0BAD_0000;
    i_wb_gpio_rdt  = (region == 1) ? srdt : 32'h0BAD_0001;
    i_wb_audio_rdt = (region == 2) ? srdt : 32'h0BAD_0002;
    m_region = region;
    m_t0     = cyc_n;
    m_delay  = delay;
    if (region == 3) begin
      m_ackc = cyc_n + 1;  m_rdt_exp = '0;   m_err_on_ack = 1'b1;
    end else if (delay >= 0 && delay <= TO) begin
      m_ackc = cyc_n + 1 + delay;  m_rdt_exp = srdt;  m_err_on_ack = 1'b0;
    end else begin
      m_ackc = cyc_n + 1 + TO;  m_rdt_exp = ERRV;  m_err_on_ack = 1'b1;
    end
    m_active = 1'b1;
  endtask

  // Full master transaction; returns ack cycle relative to the request cycle
  task automatic run(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                     input logic we, input int delay, input logic [31:0] srdt);
    bit got;
    start_txn(adr, dat, sel, we, delay, srdt);
    got = 1'b0;
    ack_off = -1;
    ack_rdt = 'x;
    for (int i = 0; i < TO + 8; i++) begin
      @(negedge clk);
      if (o_wb_ack === 1'b1) begin
        got = 1'b1;
        ack_off = cyc_n - m_t0;
        ack_rdt = o_wb_rdt;
        break;
      end
    end
    chk("ack_seen", 32'(got), 32'(1));
    @(posedge clk); #1;
    i_wb_cyc = 1'b0;
    i_wb_we  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack",     32'(o_wb_ack), 32'(0));
    chk("rst_rdt",     o_wb_rdt, 32'h0);
    chk("rst_bus_err", 32'(o_bus_err), 32'(0));
    chk("rst_err_adr", o_err_adr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Mem read, one wait state
    run(32'h0000_0010, 32'h0, 4'hF, 1'b0, 1, 32'h1234_5678);
    chk("mem_lat", 32'(ack_off), 32'(2));
    chk("mem_rdt", ack_rdt, 32'h1234_5678);

    // GPIO zero-wait write, then RECOVER has every cyc low
    run(32'h1000_0004, 32'h0000_00A5, 4'b0001, 1'b1, 0, 32'h0);
    chk("gpio_lat", 32'(ack_off), 32'(1));
    chk("gpio_s_dat", o_wb_s_dat, 32'h0000_00A5);
    @(negedge clk);
    chk("gpio_recover_cyc", 32'(o_wb_gpio_cyc), 32'(0));

    // Unmapped read and error clear
    run(32'h3000_0000, 32'h0, 4'hF, 1'b0, 0, 32'h0);
    chk("unm_lat", 32'(ack_off), 32'(1));
    chk("unm_rdt", ack_rdt, 32'h0);
    @(negedge clk);
    chk("unm_err", 32'(o_bus_err), 32'(1));
    chk("unm_err_adr", o_err_adr, 32'h3000_0000);
    @(posedge clk); #1; i_err_clr = 1'b1;
    @(posedge clk); #1; i_err_clr = 1'b0;
    @(negedge clk);
    chk("clr_err", 32'(o_bus_err), 32'(0));
    chk("clr_err_adr_held", o_err_adr, 32'h3000_0000);

    // Audio never acks: watchdog
    run(32'h2000_0008, 32'h0, 4'hF, 1'b0, -1, 32'hCAFE_0001);
    chk("to_lat", 32'(ack_off), 32'(5));
    chk("to_rdt", ack_rdt, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("to_err", 32'(o_bus_err), 32'(1));
    chk("to_err_adr", o_err_adr, 32'h2000_0008);
    @(posedge clk); #1; i_err_clr = 1'b1;
    @(posedge clk); #1; i_err_clr = 1'b0;

    // Audio ack coincides with the watchdog limit: the ack wins
    run(32'h2000_000C, 32'h0, 4'hF, 1'b0, 4, 32'hCAFE_0002);
    chk("edge_lat", 32'(ack_off), 32'(5));
    chk("edge_rdt", ack_rdt, 32'hCAFE_0002);
    @(negedge clk);
    chk("edge_no_err", 32'(o_bus_err), 32'(0));

    // Stray gpio ack while mem is selected
    stray_gpio = 1'b1;
    run(32'h0000_0020, 32'h0, 4'hF, 1'b0, 2, 32'h0DEF_ACED);
    chk("stray_lat", 32'(ack_off), 32'(3));
    chk("stray_rdt", ack_rdt, 32'h0DEF_ACED);
    stray_gpio = 1'b0;

    // Error set and clear in the same cycle: set wins
    i_err_clr = 1'b1;
    run(32'hF000_0000, 32'h0, 4'hF, 1'b0, 0, 32'h0);
    i_err_clr = 1'b0;
    @(negedge clk);
    chk("setwins_err", 32'(o_bus_err), 32'(1));
    chk("setwins_adr", o_err_adr, 32'hF000_0000);

    // Master abandons a stalled access
    start_txn(32'h0000_0040, 32'h0, 4'hF, 1'b0, -1, 32'h1111_1111);
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_wb_cyc = 1'b0;
    @(negedge clk);
    chk("abort_cyc", 32'(o_wb_mem_cyc), 32'(0));
    chk("abort_ack", 32'(o_wb_ack), 32'(0));
    run(32'h0000_0044, 32'h0, 4'hF, 1'b0, 0, 32'h2222_2222);
    chk("post_abort_lat", 32'(ack_off), 32'(1));

    // Reset in the middle of a stalled mem access
    start_txn(32'h0000_0080, 32'h0, 4'hF, 1'b0, -1, 32'h3333_3333);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    i_wb_cyc = 1'b0;
    @(negedge clk);
    chk("rstmid_ack", 32'(o_wb_ack), 32'(0));
    chk("rstmid_cyc", 32'(o_wb_mem_cyc), 32'(0));
    chk("rstmid_err", 32'(o_bus_err), 32'(0));
    chk("rstmid_err_adr", o_err_adr, 32'h0);
    run(32'h0000_0100, 32'h0, 4'hF, 1'b0, 0, 32'h5555_AAAA);
    chk("post_rst_lat", 32'(ack_off), 32'(1));
    chk("post_rst_rdt", ack_rdt, 32'h5555_AAAA);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
